// File: rtl/seq_divider_if.sv
// Start/done handshake bundle for seq_divider: operands in, quotient/remainder out.
// The controller holds the master modport, the divider the slave modport.
interface seq_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional macro DIVZERO_FLAG_EN: short-circuit divide-by-zero and raise div_by_zero.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;        // dividend shifts out MSB-first, quotient bits shift in at LSB
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    count;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic [WIDTH:0]   rem_shift;
  logic             fits;
  logic [WIDTH-1:0] rem_diff;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;

  // The shifted remainder carries one extra bit so the compare cannot overflow;
  // whenever it fits, the true difference is below 2**WIDTH, so WIDTH bits suffice.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    rem_shift = {rem, dvd[WIDTH-1]};
    fits      = (rem_shift >= {1'b0, dsr});
    rem_diff  = rem_shift[WIDTH-1:0] - dsr;
    rem_next  = fits ? rem_diff : rem_shift[WIDTH-1:0];
    q_next    = {dvd[WIDTH-2:0], fits};
  end

`ifdef DIVZERO_FLAG_EN
  logic dz_pending;
  logic div_by_zero_q;

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      dvd           <= '0;
      dsr           <= '0;
      rem           <= '0;
      count         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      dz_pending    <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd           <= bus.dividend;
            dsr           <= bus.divisor;
            rem           <= '0;
            count         <= '0;
            div_by_zero_q <= 1'b0;
            if (bus.divisor == '0) begin
              state      <= DONE;
              dz_pending <= 1'b1;
            end else begin
              state  <= RUN;
              busy_q <= 1'b1;
            end
          end
        end
        RUN: begin
          dvd   <= q_next;
          rem   <= rem_next;
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            state       <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= q_next;
            remainder_q <= rem_next;
          end
        end
        DONE: begin
          state <= IDLE;
          // Divide-by-zero result lands one edge after the short-circuited accept.
          if (dz_pending) begin
            dz_pending    <= 1'b0;
            done_q        <= 1'b1;
            quotient_q    <= '1;
            remainder_q   <= dvd;
            div_by_zero_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.div_by_zero = div_by_zero_q;
`else
  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      count       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd    <= bus.dividend;
            dsr    <= bus.divisor;
            rem    <= '0;
            count  <= '0;
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          dvd   <= q_next;
          rem   <= rem_next;
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            state       <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= q_next;
            remainder_q <= rem_next;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A zero divisor simply runs the algorithm, which yields all-ones and the dividend.
  assign bus.div_by_zero = 1'b0;
`endif

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=4): directed handshake cases plus an exhaustive sweep.
module tb_seq_divider;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
`ifdef DIVZERO_FLAG_EN
      e.dz = 1'b1;
`else
      e.dz = 1'b0;
`endif
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pushed expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("quotient", 32'(bus.quotient), 32'(e.q));
          check("remainder", 32'(bus.remainder), 32'(e.r));
          check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
        end
      end
    end
  end

  // Counts negedges until done (first negedge after the accepting edge is 1).
  task automatic wait_done(output int n, output int busy_cycles);
    n = 0;
    busy_cycles = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.done !== 1'b1 && bus.busy === 1'b1) busy_cycles++;
    end while (bus.done !== 1'b1 && n < 30);
    if (bus.done !== 1'b1) begin
      check("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    int bc;
    int exp_edges;
    int exp_busy;
    exp_edges = W;
    exp_busy  = W;
`ifdef DIVZERO_FLAG_EN
    if (b == 0) begin
      exp_edges = 1;
      exp_busy  = 0;
    end
`endif
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = ~a;
    bus.divisor  = ~b;
    wait_done(n, bc);
    check("latency", 32'(n - 1), 32'(exp_edges));
    check("busy_cycles", 32'(bc), 32'(exp_busy));
    check("busy_at_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  initial begin
    int n;
    int bc;
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;

    // Reset held two cycles with start asserted.
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_quotient", 32'(bus.quotient), 32'd0);
      check("rst_remainder", 32'(bus.remainder), 32'd0);
      check("rst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);

    // Basic function and boundaries.
    run_div(4'd13, 4'd3);
    run_div(4'd15, 4'd1);
    run_div(4'd2, 4'd3);
    run_div(4'd0, 4'd7);

    // Divide by zero.
    run_div(4'd9, 4'd0);
    run_div(4'd5, 4'd2);

    // Start held through RUN/DONE: ignored until the first IDLE cycle.
    bus.start    = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    sb.push_back(model(4'd13, 4'd3));
    @(posedge clk);
    #1;
    bus.dividend = 4'd6;
    bus.divisor  = 4'd2;
    wait_done(n, bc);
    check("held_first_latency", 32'(n - 1), 32'(W));
    sb.push_back(model(4'd6, 4'd2));
    wait_done(n, bc);
    check("held_second_spacing", 32'(n), 32'(W + 2));
    bus.start = 1'b0;
    @(negedge clk);

    // Reset mid-RUN aborts the operation.
    bus.start    = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_quotient", 32'(bus.quotient), 32'd0);
    check("abort_remainder", 32'(bus.remainder), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_idle_busy", 32'(bus.busy), 32'd0);
    run_div(4'd7, 4'd2);

    // Exhaustive sweep of nonzero divisors.
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_div(W'(a), W'(b));
      end
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
